demux_1to7_32bits_reg: RTL and testbench

//   Registered 1-to-7 distributor, the write-side counterpart of the 7:1 32-bit

---
 rtl/demux_1to7_32bits_reg.sv | 90 +++++++++
 tb/tb_demux_1to7_32bits_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux_1to7_32bits_reg.sv
// Purpose: registered 1-to-7 distributor with a per-slot valid/ack handshake and sticky error flags.
// Latency: a write or ack presented before a rising edge is visible right after that edge (1 cycle).
// Backpressure: none is applied to the producer; a write to an unconsumed slot overwrites it and sets Overflow.
module demux_1to7_32bits_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       Select,
  input  logic             Load,
  input  logic [6:0]       Ack,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [6:0]       Valid,
  output logic             Overflow,
  output logic             SelErr
);

  localparam int unsigned NSLOT = 7;

  logic [WIDTH-1:0] o_q [NSLOT];
  logic [WIDTH-1:0] o_d [NSLOT];
  logic [6:0]       valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             selerr_q, selerr_d;
  logic             ovf_set;
  logic             bad_sel;

  // Next-state for every slot: a load beats an ack on the same slot, and
  // overflow is only raised when the old word was neither consumed nor acked.
  always_comb begin
    ovf_set = 1'b0;
    valid_d = valid_q;
    for (int k = 0; k < NSLOT; k++) begin
      o_d[k] = o_q[k];
      if (Load && (Select == 3'(k))) begin
        o_d[k]     = I;
        valid_d[k] = 1'b1;
        if (valid_q[k] && !Ack[k]) begin
          ovf_set = 1'b1;
        end
      end else if (Ack[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    bad_sel  = Load && (Select == 3'b111);
    // A set condition in the same cycle as ClrErr wins.
    ovf_d    = ovf_set | (ovf_q    & ~ClrErr);
    selerr_d = bad_sel | (selerr_q & ~ClrErr);
  end

  // State registers; reset discards any load/ack presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSLOT; k++) begin
        o_q[k] <= RESET_VAL;
      end
      valid_q  <= '0;
      ovf_q    <= 1'b0;
      selerr_q <= 1'b0;
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        o_q[k] <= o_d[k];
      end
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      selerr_q <= selerr_d;
    end
  end

  assign O0       = o_q[0];
  assign O1       = o_q[1];
  assign O2       = o_q[2];
  assign O3       = o_q[3];
  assign O4       = o_q[4];
  assign O5       = o_q[5];
  assign O6       = o_q[6];
  assign Valid    = valid_q;
  assign Overflow = ovf_q;
  assign SelErr   = selerr_q;

endmodule

// File: tb/tb_demux_1to7_32bits_reg.sv
// Directed bench for demux_1to7_32bits_reg.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// Expected values are written by hand for each step.
module tb_demux_1to7_32bits_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] I;
  logic [2:0]  Select;
  logic        Load;
  logic [6:0]  Ack;
  logic        ClrErr;
  logic [31:0] O0, O1, O2, O3, O4, O5, O6;
  logic [6:0]  Valid;
  logic        Overflow;
  logic        SelErr;

  logic [31:0] obs_o [7];
  logic [31:0] exp_o [7];
  int checks = 0;
  int passed = 0;

  demux_1to7_32bits_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk(clk), .reset(reset), .I(I), .Select(Select), .Load(Load),
    .Ack(Ack), .ClrErr(ClrErr),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6),
    .Valid(Valid), .Overflow(Overflow), .SelErr(SelErr)
  );

  always #5 clk = ~clk;

  assign obs_o[0] = O0;
  assign obs_o[1] = O1;
  assign obs_o[2] = O2;
  assign obs_o[3] = O3;
  assign obs_o[4] = O4;
  assign obs_o[5] = O5;
  assign obs_o[6] = O6;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_slots(input string tag);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s O%0d", tag, k), obs_o[k], exp_o[k]);
    end
  endtask

  initial begin
    reset = 1'b1; I = '0; Select = '0; Load = 1'b0; Ack = '0; ClrErr = 1'b0;
    for (int k = 0; k < 7; k++) exp_o[k] = 32'h0;

    // 1. reset for two cycles
    step(); step();
    reset = 1'b0;
    check_slots("reset");
    check("reset Valid", {25'h0, Valid}, 32'h00);
    check("reset Overflow", {31'h0, Overflow}, 32'h0);
    check("reset SelErr", {31'h0, SelErr}, 32'h0);

    // 2. write slot 3, then ack it
    Load = 1'b1; Select = 3'd3; I = 32'hDEADBEEF;
    step();
    Load = 1'b0;
    exp_o[3] = 32'hDEADBEEF;
    check_slots("wr3");
    check("wr3 Valid", {25'h0, Valid}, 32'h08);
    Ack = 7'b0001000;
    step();
    Ack = '0;
    check("ack3 Valid", {25'h0, Valid}, 32'h00);
    check("ack3 O3", O3, 32'hDEADBEEF);

    // 3. overwrite unconsumed slot 5 -> Overflow, then clear it
    Load = 1'b1; Select = 3'd5; I = 32'h11;
    step();
    check("wr5a Overflow", {31'h0, Overflow}, 32'h0);
    I = 32'h22;
    step();
    Load = 1'b0;
    exp_o[5] = 32'h22;
    check("ovf O5", O5, 32'h22);
    check("ovf Valid", {25'h0, Valid}, 32'h20);
    check("ovf Overflow", {31'h0, Overflow}, 32'h1);
    step();
    check("ovf sticky", {31'h0, Overflow}, 32'h1);
    ClrErr = 1'b1;
    step();
    ClrErr = 1'b0;
    check("clr Overflow", {31'h0, Overflow}, 32'h0);

    // 4. load slot 0 while it is valid and acked in the same cycle
    Load = 1'b1; Select = 3'd0; I = 32'h5A;
    step();
    I = 32'hA5; Ack = 7'b0000001;
    step();
    Load = 1'b0; Ack = '0;
    exp_o[0] = 32'hA5;
    check("ldack O0", O0, 32'hA5);
    check("ldack Valid", {25'h0, Valid}, 32'h21);
    check("ldack Overflow", {31'h0, Overflow}, 32'h0);

    // load slot 1 while acking slot 5: independent effects
    Load = 1'b1; Select = 3'd1; I = 32'h77; Ack = 7'b0100000;
    step();
    Load = 1'b0; Ack = '0;
    exp_o[1] = 32'h77;
    check_slots("ld1ack5");
    check("ld1ack5 Valid", {25'h0, Valid}, 32'h03);

    // 5. bad select writes nothing, sets SelErr
    Load = 1'b1; Select = 3'b111; I = 32'hFFFFFFFF;
    step();
    Load = 1'b0;
    check_slots("badsel");
    check("badsel Valid", {25'h0, Valid}, 32'h03);
    check("badsel SelErr", {31'h0, SelErr}, 32'h1);
    check("badsel Overflow", {31'h0, Overflow}, 32'h0);
    Load = 1'b1; ClrErr = 1'b1;
    step();
    Load = 1'b0; ClrErr = 1'b0;
    check("badsel+clr SelErr", {31'h0, SelErr}, 32'h1);
    ClrErr = 1'b1;
    step();
    ClrErr = 1'b0;
    check("clr SelErr", {31'h0, SelErr}, 32'h0);

    // overflow set beats ClrErr in the same cycle (slot 1 still valid)
    Load = 1'b1; Select = 3'd1; I = 32'h88; ClrErr = 1'b1;
    step();
    Load = 1'b0; ClrErr = 1'b0;
    exp_o[1] = 32'h88;
    check("ovf+clr O1", O1, 32'h88);
    check("ovf+clr Overflow", {31'h0, Overflow}, 32'h1);

    // ack of all slots: only the valid ones drop, data kept
    Ack = 7'h7F; ClrErr = 1'b1;
    step();
    Ack = '0; ClrErr = 1'b0;
    check("ackall Valid", {25'h0, Valid}, 32'h00);
    check_slots("ackall");

    // 6. fill all slots with 1..7, then reset with a load pending
    for (int k = 0; k < 7; k++) begin
      Load = 1'b1; Select = 3'(k); I = 32'(k + 1);
      step();
      exp_o[k] = 32'(k + 1);
    end
    Load = 1'b0;
    check_slots("fill");
    check("fill Valid", {25'h0, Valid}, 32'h7F);
    check("fill Overflow", {31'h0, Overflow}, 32'h0);
    reset = 1'b1; Load = 1'b1; Select = 3'd2; I = 32'h99; Ack = 7'b0000100;
    step();
    reset = 1'b0; Load = 1'b0; Ack = '0;
    for (int k = 0; k < 7; k++) exp_o[k] = 32'h0;
    check_slots("rst");
    check("rst Valid", {25'h0, Valid}, 32'h00);
    check("rst Overflow", {31'h0, Overflow}, 32'h0);
    check("rst SelErr", {31'h0, SelErr}, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
